// File: rtl/decoder_pkg.sv
// Shared widths, the queued {en, code} entry, and the one-hot decode used by the stream decoder.
// Pure definitions: no latency, no flow control.
package decoder_pkg;
   localparam int CODE_W     = 3;
   localparam int ONEHOT_W   = 8;
   localparam int FIFO_DEPTH = 2;
   localparam int ENTRY_W    = 1 + CODE_W;

   typedef struct packed {
      logic              en;
      logic [CODE_W-1:0] code;
   } entry_t;

   function automatic logic [ONEHOT_W-1:0] decode(input entry_t e);
      decode = e.en ? (ONEHOT_W'(1) << e.code) : '0;
   endfunction
endpackage

// File: rtl/decoder_fifo2.sv
// Two-entry skid FIFO of {en, code}; the head is visible combinationally, and a write lands one cycle later.
// Backpressure: a push while full and a pop while empty are both ignored, so the caller gates push with ~o_full.
module decoder_fifo2
   import decoder_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               i_push,
   input  logic [ENTRY_W-1:0] i_dat,
   input  logic               i_pop,
   output logic [ENTRY_W-1:0] o_head,
   output logic [1:0]         o_count,
   output logic               o_full,
   output logic               o_empty
);
   logic [ENTRY_W-1:0] r_mem [0:FIFO_DEPTH-1];
   logic               r_wr_ptr;
   logic               r_rd_ptr;
   logic [1:0]         r_count;
   logic               w_push;
   logic               w_pop;

   assign o_full  = (r_count == 2'(FIFO_DEPTH));
   assign o_empty = (r_count == 2'd0);
   assign o_count = r_count;
   assign o_head  = r_mem[r_rd_ptr];
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) r_wr_ptr <= ~r_wr_ptr;
         if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Entry storage needs no reset: the pointers and count define which entries are live.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_dat;
   end
endmodule

// File: rtl/decoder_3x8_stream.sv
// Valid/ready 3-to-8 decoder: one output register fed either from a 2-entry FIFO or directly from the input (1-cycle latency).
// in_ready depends only on the FIFO fill level; the output is held while out_ready is low.
module decoder_3x8_stream
   import decoder_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [CODE_W-1:0]   in_code,
   input  logic                in_en,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [ONEHOT_W-1:0] out_onehot,
   output logic [CNT_W-1:0]    dec_count
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic                r_out_valid;
   logic [ONEHOT_W-1:0] r_out_onehot;
   logic [CNT_W-1:0]    r_dec_count;

   entry_t              w_in_entry;
   entry_t              w_head;
   logic [1:0]          w_fifo_count;
   logic                w_fifo_full;
   logic                w_fifo_empty;
   logic                w_in_fire;
   logic                w_out_fire;
   logic                w_free;
   logic                w_pop;
   logic                w_bypass;
   logic                w_push;

   assign w_in_entry = {in_en, in_code};
   assign in_ready   = (w_fifo_count < 2'(FIFO_DEPTH));
   assign w_in_fire  = in_valid & ~w_fifo_full;
   assign w_out_fire = r_out_valid & out_ready;
   assign w_free     = ~r_out_valid | out_ready;
   assign w_pop      = w_free & ~w_fifo_empty;
   // Bypass only when nothing is queued, so arrival order is preserved.
   assign w_bypass   = w_in_fire & w_free & w_fifo_empty;
   assign w_push     = w_in_fire & ~w_bypass;

   decoder_fifo2 u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_dat   (w_in_entry),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_count (w_fifo_count),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid  <= 1'b0;
         r_out_onehot <= '0;
      end else if (w_free) begin
         if (w_pop) begin
            r_out_valid  <= 1'b1;
            r_out_onehot <= decode(w_head);
         end else if (w_bypass) begin
            r_out_valid  <= 1'b1;
            r_out_onehot <= decode(w_in_entry);
         end else begin
            r_out_valid  <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_dec_count <= '0;
      end else if (w_out_fire && (r_out_onehot != '0) && (r_dec_count != CNT_MAX)) begin
         r_dec_count <= r_dec_count + 1'b1;
      end
   end

   assign out_valid  = r_out_valid;
   assign out_onehot = r_out_onehot;
   assign dec_count  = r_dec_count;
endmodule

// File: tb/tb_decoder_3x8_stream.sv
// Bench: a negedge scoreboard checks every output of both instances (CNT_W=8 and CNT_W=2).
// Directed tables and sequences cover reset, decode, backpressure, saturation and mid-flight reset.
module tb_decoder_3x8_stream;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_en = 1'b0;
   logic [2:0] in_code = 3'd0;
   logic       out_ready = 1'b0;

   logic       in_ready, out_valid;
   logic [7:0] out_onehot, dec_count;
   logic       in_ready2, out_valid2;
   logic [7:0] out_onehot2;
   logic [1:0] dec_count2;

   int errors = 0;
   int checks = 0;
   logic [7:0] sb_q[$];
   int exp_cnt  = 0;
   int exp_cnt2 = 0;

   always #5 clk = ~clk;

   decoder_3x8_stream #(.CNT_W(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_code(in_code), .in_en(in_en), .out_valid(out_valid),
      .out_ready(out_ready), .out_onehot(out_onehot), .dec_count(dec_count)
   );

   decoder_3x8_stream #(.CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
      .in_code(in_code), .in_en(in_en), .out_valid(out_valid2),
      .out_ready(out_ready), .out_onehot(out_onehot2), .dec_count(dec_count2)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, req);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: handshakes sampled mid-cycle complete at the next rising edge.
   always @(negedge clk) begin
      logic [7:0] e;
      if (rst) begin
         sb_q.delete();
         exp_cnt  = 0;
         exp_cnt2 = 0;
      end else begin
         chk("dec_count", 32'(dec_count), 32'(exp_cnt));
         chk("dec_count_w2", 32'(dec_count2), 32'(exp_cnt2));
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL stale_output: got %0h expected no output", out_onehot);
            end else begin
               e = sb_q.pop_front();
               chk("out_onehot", 32'(out_onehot), 32'(e));
               chk("out_valid_w2", 32'(out_valid2), 32'd1);
               chk("out_onehot_w2", 32'(out_onehot2), 32'(e));
               if (e != 8'h00) begin
                  if (exp_cnt < 255) exp_cnt++;
                  if (exp_cnt2 < 3) exp_cnt2++;
               end
            end
         end
         if (in_valid && in_ready) sb_q.push_back(in_en ? (8'h01 << in_code) : 8'h00);
      end
   end

   typedef struct {
      logic [2:0] code;
      logic       en;
      logic [7:0] exp;
   } vec_t;

   initial begin
      vec_t       tbl[10];
      logic       rdy_exp[4];
      logic [7:0] ord_exp[4];
      logic [7:0] got[4];
      logic [1:0] sat_exp[5];
      int         n_got;
      logic       acc;

      tbl[0] = '{3'd0, 1'b1, 8'h01};
      tbl[1] = '{3'd1, 1'b1, 8'h02};
      tbl[2] = '{3'd2, 1'b1, 8'h04};
      tbl[3] = '{3'd3, 1'b1, 8'h08};
      tbl[4] = '{3'd4, 1'b1, 8'h10};
      tbl[5] = '{3'd5, 1'b1, 8'h20};
      tbl[6] = '{3'd6, 1'b1, 8'h40};
      tbl[7] = '{3'd7, 1'b1, 8'h80};
      tbl[8] = '{3'd7, 1'b0, 8'h00};
      tbl[9] = '{3'd3, 1'b0, 8'h00};
      rdy_exp = '{1'b1, 1'b1, 1'b1, 1'b0};
      ord_exp = '{8'h01, 8'h02, 8'h04, 8'h08};
      sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_onehot", 32'(out_onehot), 32'h00);
      chk("rst_dec_count", 32'(dec_count), 32'd0);
      rst = 1'b0;
      cyc();
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      // Single code 5 with bypass latency of one cycle
      out_ready = 1'b1;
      in_valid = 1'b1; in_code = 3'd5; in_en = 1'b1;
      cyc();
      in_valid = 1'b0;
      chk("c5_out_valid", 32'(out_valid), 32'd1);
      chk("c5_out_onehot", 32'(out_onehot), 32'h20);
      cyc();
      chk("c5_dec_count", 32'(dec_count), 32'd1);
      chk("c5_drained", 32'(out_valid), 32'd0);

      // Every code, plus disabled decodes
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1; in_code = tbl[i].code; in_en = tbl[i].en;
         cyc();
         in_valid = 1'b0;
         chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'd1);
         chk($sformatf("tbl%0d_onehot", i), 32'(out_onehot), 32'(tbl[i].exp));
         cyc();
      end
      chk("tbl_dec_count", 32'(dec_count), 32'd9);

      // Backpressure: three accepted, fourth stalls, order preserved on release
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_code = 3'(i); in_en = 1'b1;
         chk($sformatf("bp_in_ready%0d", i), 32'(in_ready), 32'(rdy_exp[i]));
         chk($sformatf("bp_in_ready_w2_%0d", i), 32'(in_ready2), 32'(rdy_exp[i]));
         cyc();
      end
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_onehot", 32'(out_onehot), 32'h01);
      out_ready = 1'b1;
      got = '{8'h00, 8'h00, 8'h00, 8'h00};
      n_got = 0;
      for (int t = 0; t < 20 && n_got < 4; t++) begin
         acc = in_valid && in_ready;
         if (out_valid && out_ready) begin
            got[n_got] = out_onehot;
            n_got++;
         end
         cyc();
         if (acc) in_valid = 1'b0;
      end
      in_valid = 1'b0;
      chk("bp_count", 32'(n_got), 32'd4);
      for (int i = 0; i < 4; i++) chk($sformatf("bp_order%0d", i), 32'(got[i]), 32'(ord_exp[i]));
      repeat (3) cyc();

      // Reset while three entries are buffered, with a handshake in the reset cycle
      out_ready = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         in_valid = 1'b1; in_code = 3'(i); in_en = 1'b1;
         cyc();
      end
      rst = 1'b1; in_code = 3'd6;
      cyc();
      chk("mrst_out_valid", 32'(out_valid), 32'd0);
      chk("mrst_out_onehot", 32'(out_onehot), 32'h00);
      chk("mrst_dec_count", 32'(dec_count), 32'd0);
      chk("mrst_dec_count_w2", 32'(dec_count2), 32'd0);
      chk("mrst_in_ready", 32'(in_ready), 32'd1);
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk($sformatf("mrst_idle%0d", i), 32'(out_valid), 32'd0);
      end

      // Saturation on the 2-bit counter
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_code = 3'd2; in_en = 1'b1;
         cyc();
         in_valid = 1'b0;
         cyc();
         chk($sformatf("sat%0d", i), 32'(dec_count2), 32'(sat_exp[i]));
      end

      // Random traffic against the scoreboard
      for (int i = 0; i < 10000; i++) begin
         in_valid  = ($urandom_range(0, 9) < 6);
         in_code   = 3'($urandom_range(0, 7));
         in_en     = ($urandom_range(0, 4) != 0);
         out_ready = ($urandom_range(0, 9) < 5);
         cyc();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (10) cyc();
      chk("rand_drained", 32'(sb_q.size()), 32'd0);
      chk("rand_idle", 32'(out_valid), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/decoder_3x8_stream.md
DECODER_3X8_STREAM -- requirements
Module: decoder_3x8_stream

Interface
REQ-001 Parameter: CNT_W, default 8, width of the saturating decode-event counter.
REQ-002 Port: clk  input  1  single clock; all logic samples on its rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: in_valid  input  1  producer asserts that in_code/in_en are valid.
REQ-005 Port: in_ready  output  1  block can accept an input this cycle.
REQ-006 Port: in_code  input  3  binary code 0..7 to decode.
REQ-007 Port: in_en  input  1  decode enable, travels with the code; 0 yields all-zero output.
REQ-008 Port: out_valid  output  1  out_onehot holds a decoded result.
REQ-009 Port: out_ready  input  1  consumer accepts the output this cycle.
REQ-010 Port: out_onehot  output  8  registered decode result, bit[in_code] set when in_en=1.
REQ-011 Port: dec_count  output  CNT_W  saturating count of accepted nonzero outputs.

Function
REQ-012 Input transfer SHALL occur on a rising edge where in_valid=1 and in_ready=1; output transfer SHALL occur where out_valid=1 and out_ready=1.
REQ-013 Storage SHALL be one output register plus a 2-entry FIFO of {in_en, in_code}; total capacity 3 entries.
REQ-014 in_ready SHALL equal (fifo_count < 2), combinationally from registered state only (no path from in_valid or out_ready).
REQ-015 Output register SHALL be "free" when out_valid=0 or an output transfer occurs this cycle.
REQ-016 When output register free and FIFO non-empty: FIFO head loads output register; an input transfer the same cycle writes the FIFO (count unchanged on simultaneous push/pop).
REQ-017 When output register free and FIFO empty: an input transfer SHALL load the output register directly (bypass), giving 1-cycle latency from input transfer to out_valid=1.
REQ-018 When output register not free: an input transfer SHALL write the FIFO; out_onehot/out_valid SHALL hold stable while out_valid=1 and out_ready=0.
REQ-019 When output register free and no source available: out_valid SHALL go 0 next cycle.
REQ-020 Loaded value: out_onehot = 8'h01 << code if en=1, else 8'h00; the result with en=0 SHALL still be a valid, handshaken output.
REQ-021 Order SHALL be strictly preserved (FIFO order; bypass only when FIFO empty).
REQ-022 dec_count SHALL increment by 1 on each output transfer with out_onehot != 0, and saturate at 2^CNT_W-1 (no wrap).
REQ-023 in_valid with in_ready=0 SHALL have no effect; no data lost or duplicated under any ready/valid pattern.

Reset
REQ-024 With rst=1 at a rising edge: out_valid=0, out_onehot=8'h00, fifo_count=0, dec_count=0; in_ready=1 from the following cycle.
REQ-025 Reset mid-operation SHALL discard all buffered entries; handshakes in the reset cycle SHALL be ignored.

Structure
REQ-026 Package decoder_pkg SHALL hold CODE_W=3, ONEHOT_W=8, FIFO_DEPTH=2 and the entry struct {en, code}.
REQ-027 The 2-entry FIFO SHALL be a sub-module decoder_fifo2 (push, pop, head, count, full, empty); decode and counter logic stay in the top.

Verification
REQ-028 Reset, then in_code=5,en=1 for one cycle with out_ready=1 -> next cycle out_valid=1, out_onehot=8'h20; dec_count=1 after transfer.
REQ-029 out_ready=0, push codes 0,1,2,3 back-to-back -> 3 accepted (out_onehot=8'h01 held), in_ready=0 on 4th; release out_ready -> 8'h01,8'h02,8'h04 then 8'h08 in order.
REQ-030 Push code 7 with en=0 -> out_valid=1, out_onehot=8'h00, dec_count unchanged.
REQ-031 CNT_W=2, 5 nonzero output transfers -> dec_count sequence 1,2,3,3,3.
REQ-032 Fill 3 entries, assert rst one cycle -> out_valid=0, out_onehot=8'h00, dec_count=0, in_ready=1 next cycle, no stale output afterwards.
REQ-033 Random in_valid/out_ready (10k cycles) against a scoreboard -> every output equals 1<<code (or 0 when en=0), in order, none dropped or duplicated.
